frame_timer: RTL and testbench
==============================

FRAME_TIMER -- requirements
Module: frame_timer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter CLK_HZ, default 1000000, clock frequency in Hz.
REQ-003 Parameter FPS, default 60, frames per second; PERIOD = CLK_HZ/FPS (integer division), legal only when PERIOD >= 2.
REQ-004 Parameter CNT_W, default 32, frame counter width.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 run  input  1  level: 1 = advance timebase, 0 = pause.
REQ-008 restart  input  1  synchronous clear of timebase and counters.
REQ-009 frame_ack  input  1  consumer has finished the outstanding frame.
REQ-010 frame_tick  output  1  one-cycle registered frame pulse.
REQ-011 frame_busy  output  1  a tick was issued and not yet acknowledged.
REQ-012 frame_cnt  output  CNT_W  count of issued ticks.
REQ-013 drop_cnt  output  16  count of dropped frames.

Function
REQ-014 The block SHALL implement the states IDLE, RUN and PAUSE: IDLE->RUN on run=1; RUN->PAUSE on run=0; PAUSE->RUN on run=1; any state->IDLE on restart=1.
REQ-015 Divider div (0..PERIOD-1) SHALL hold at 0 in IDLE, increment each RUN cycle, hold its value in PAUSE, and wrap from PERIOD-1 to 0.
REQ-016 A frame event SHALL occur at an edge where state=RUN and div=PERIOD-1.
REQ-017 On a frame event with frame_busy=0 or frame_ack=1, the block SHALL set frame_tick=1 for exactly one cycle, increment frame_cnt, and keep/set frame_busy=1.
REQ-018 On a frame event with frame_busy=1 and frame_ack=0, the block SHALL suppress the tick, leave frame_cnt unchanged, and increment drop_cnt.
REQ-019 Latency: if run is first sampled high in IDLE at edge E0, the first frame_tick SHALL be high immediately after edge E0+PERIOD; later ticks SHALL follow every PERIOD RUN cycles.
REQ-020 frame_busy SHALL clear at an edge where frame_ack=1 and no tick is issued; frame_ack with frame_busy=0 SHALL be ignored.
REQ-021 frame_ack SHALL be honoured in every state, including PAUSE.
REQ-022 frame_cnt SHALL wrap from 2^CNT_W-1 to 0.
REQ-023 drop_cnt SHALL saturate at 16'hFFFF.
REQ-024 restart SHALL clear div, frame_tick, frame_busy, frame_cnt and drop_cnt, and SHALL take priority over run and frame_ack in the same cycle.

Reset
REQ-025 When rst=1 at an edge, the block SHALL enter IDLE with div=0, frame_tick=0, frame_busy=0, frame_cnt=0 and drop_cnt=0.
REQ-026 rst SHALL take priority over every other input, including mid-frame and in PAUSE.

Configuration
REQ-027 With macro FRAME_TIMER_DROP_CNT_EN defined, drop_cnt SHALL behave per REQ-018 and REQ-023.
REQ-028 Without FRAME_TIMER_DROP_CNT_EN, drop_cnt SHALL be driven constant 0 and no counter register SHALL be built; tick suppression per REQ-018 SHALL be unchanged.

Verification (CLK_HZ=600, FPS=60, so PERIOD=10, unless stated)
REQ-029 rst, then run=1 from E0, frame_ack pulsed in each tick cycle -> ticks after E10, E20 and E30; frame_cnt=1,2,3; drop_cnt=0.
REQ-030 run=1 from E0, frame_ack never asserted -> single tick after E10; frame_busy=1 throughout; drop_cnt=2 after E30; frame_cnt=1.
REQ-031 run dropped at div=4 for 7 cycles, then raised -> no tick during PAUSE; next tick 6 RUN cycles after resume.
REQ-032 CNT_W=4, 16 acknowledged frames -> frame_cnt sequence ends 15 then 0.
REQ-033 frame_ack=1 coincident with a frame event while busy -> tick issued, frame_busy stays 1, drop_cnt unchanged.
REQ-034 restart at div=7 with frame_busy=1 and drop_cnt=3 -> all outputs 0 next cycle; state IDLE; next tick PERIOD cycles after run is re-sampled high.

Source files
------------

// File: rtl/frame_timer_if.sv
// frame_timer_if: control inputs and frame status outputs of frame_timer.
interface frame_timer_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             restart;
    logic             frame_ack;
    logic             frame_tick;
    logic             frame_busy;
    logic [CNT_W-1:0] frame_cnt;
    logic [15:0]      drop_cnt;

    modport master (
        output run, restart, frame_ack,
        input  frame_tick, frame_busy, frame_cnt, drop_cnt
    );

    modport slave (
        input  run, restart, frame_ack,
        output frame_tick, frame_busy, frame_cnt, drop_cnt
    );
endinterface

// File: rtl/frame_timer.sv
// frame_timer: frame-rate tick generator with consumer handshake and dropped-frame tracking.
// Define FRAME_TIMER_DROP_CNT_EN to build the saturating dropped-frame counter.
module frame_timer #(
    parameter int CLK_HZ = 1000000,
    parameter int FPS    = 60,
    parameter int CNT_W  = 32
) (
    input logic          clk,
    input logic          rst,
    frame_timer_if.slave bus
);
    localparam int PERIOD = CLK_HZ / FPS;
    localparam int DIV_W  = $clog2(PERIOD);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic             tick_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic             frame_evt;
    logic             tick_d;

    assign frame_evt = state_q == RUN && div_q == DIV_W'(PERIOD - 1);
    // An ack arriving with the event frees the slot just in time for the new tick.
    assign tick_d    = frame_evt && (!busy_q || bus.frame_ack);

    always_ff @(posedge clk) begin
        if (rst || bus.restart) begin
            state_q <= IDLE;
            div_q   <= '0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= bus.run ? RUN : (state_q == RUN ? PAUSE : state_q);
            if (state_q == RUN)
                div_q <= frame_evt ? '0 : div_q + 1'b1;
            tick_q  <= tick_d;
            busy_q  <= tick_d || (busy_q && !bus.frame_ack);
            cnt_q   <= cnt_q + CNT_W'(tick_d);
        end
    end

    assign bus.frame_tick = tick_q;
    assign bus.frame_busy = busy_q;
    assign bus.frame_cnt  = cnt_q;

`ifdef FRAME_TIMER_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst || bus.restart)
            drop_q <= '0;
        else if (frame_evt && busy_q && !bus.frame_ack && drop_q != 16'hFFFF)
            drop_q <= drop_q + 1'b1;
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_frame_timer.sv
// tb_frame_timer: directed test of frame_timer (PERIOD=10) against a RUN-cycle counting model,
// with a second CNT_W=4 instance sharing the stimulus to exercise counter wrap.
module tb_frame_timer;
    localparam int PERIOD = 10;
`ifdef FRAME_TIMER_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic restart = 1'b0;
    logic ack = 1'b0;
    bit   auto_ack = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    frame_timer_if #(.CNT_W(32)) ifa ();
    frame_timer_if #(.CNT_W(4))  ifb ();

    assign ifa.run = run;
    assign ifa.restart = restart;
    assign ifa.frame_ack = ack;
    assign ifb.run = run;
    assign ifb.restart = restart;
    assign ifb.frame_ack = ack;

    frame_timer #(.CLK_HZ(600), .FPS(60), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(ifa));
    frame_timer #(.CLK_HZ(600), .FPS(60), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(ifb));

    // Model: the timebase advances in every cycle following an edge that sampled run high;
    // a frame falls due every PERIOD-th such cycle.
    longint m_n = 0;
    longint m_cnt = 0;
    int     m_drop = 0;
    bit     m_running = 1'b0;
    bit     m_tick = 1'b0;
    bit     m_busy = 1'b0;

    always @(posedge clk) begin : model
        bit evt;
        bit issue;
        if (rst || restart) begin
            m_n = 0; m_cnt = 0; m_drop = 0;
            m_running = 1'b0; m_tick = 1'b0; m_busy = 1'b0;
        end else begin
            evt = m_running && (m_n % PERIOD == PERIOD - 1);
            issue = evt && (!m_busy || ack);
            if (m_running) m_n++;
            m_tick = issue;
            m_busy = issue || (m_busy && !ack);
            if (issue) m_cnt++;
            if (evt && !issue && m_drop < 65535) m_drop++;
            m_running = run;
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance k cycles, comparing both DUTs to the model at every falling edge.
    task automatic cyc(int k);
        repeat (k) begin
            @(negedge clk);
            check("tick", 32'(ifa.frame_tick), 32'(m_tick));
            check("busy", 32'(ifa.frame_busy), 32'(m_busy));
            check("cnt", ifa.frame_cnt, 32'(m_cnt));
            check("drop", 32'(ifa.drop_cnt), DROP_EN ? 32'(m_drop) : 32'd0);
            check("tick4", 32'(ifb.frame_tick), 32'(m_tick));
            check("cnt4", 32'(ifb.frame_cnt), 32'(m_cnt % 16));
            if (auto_ack) ack = m_tick;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        check("rst_tick", 32'(ifa.frame_tick), 32'd0);
        check("rst_cnt", ifa.frame_cnt, 32'd0);
        // Acked frames: ticks after E10, E20, E30, then run on to wrap the 4-bit counter.
        rst = 1'b0; run = 1'b1; auto_ack = 1'b1;
        cyc(11);
        check("a_tick1", 32'(ifa.frame_tick), 32'd1);
        check("a_cnt1", ifa.frame_cnt, 32'd1);
        cyc(10);
        check("a_cnt2", ifa.frame_cnt, 32'd2);
        cyc(10);
        check("a_cnt3", ifa.frame_cnt, 32'd3);
        check("a_drop", 32'(ifa.drop_cnt), 32'd0);
        repeat (12) cyc(10);
        check("w_cnt15", 32'(ifb.frame_cnt), 32'd15);
        cyc(10);
        check("w_cnt0", 32'(ifb.frame_cnt), 32'd0);
        check("w_cnt16", ifa.frame_cnt, 32'd16);
        // Never acked: one tick, then drops at E20 and E30.
        auto_ack = 1'b0; ack = 1'b0; rst = 1'b1; run = 1'b0;
        cyc(1);
        rst = 1'b0; run = 1'b1;
        cyc(11);
        check("b_tick", 32'(ifa.frame_tick), 32'd1);
        cyc(20);
        check("b_busy", 32'(ifa.frame_busy), 32'd1);
        check("b_cnt", ifa.frame_cnt, 32'd1);
        check("b_drop", 32'(ifa.drop_cnt), DROP_EN ? 32'd2 : 32'd0);
        // Ack coincident with the E40 event while busy.
        cyc(9);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        check("c_tick", 32'(ifa.frame_tick), 32'd1);
        check("c_busy", 32'(ifa.frame_busy), 32'd1);
        check("c_cnt", ifa.frame_cnt, 32'd2);
        check("c_drop", 32'(ifa.drop_cnt), DROP_EN ? 32'd2 : 32'd0);
        // Restart at div=7 with busy set and three drops, run and ack also high.
        cyc(17);
        check("d_drop", 32'(ifa.drop_cnt), DROP_EN ? 32'd3 : 32'd0);
        restart = 1'b1; ack = 1'b1;
        cyc(1);
        check("d_busy0", 32'(ifa.frame_busy), 32'd0);
        check("d_cnt0", ifa.frame_cnt, 32'd0);
        check("d_drop0", 32'(ifa.drop_cnt), 32'd0);
        restart = 1'b0; ack = 1'b0;
        cyc(10);
        check("d_early", 32'(ifa.frame_tick), 32'd0);
        cyc(1);
        check("d_tick", 32'(ifa.frame_tick), 32'd1);
        // Pause with div=4 for 7 cycles: tick 6 RUN cycles after resume.
        rst = 1'b1; run = 1'b0;
        cyc(1);
        rst = 1'b0; run = 1'b1;
        cyc(4);
        run = 1'b0;
        cyc(7);
        check("p_cnt", ifa.frame_cnt, 32'd0);
        run = 1'b1;
        cyc(6);
        check("p_early", 32'(ifa.frame_tick), 32'd0);
        cyc(1);
        check("p_tick", 32'(ifa.frame_tick), 32'd1);
        // Reset while paused overrides run and ack.
        run = 1'b0;
        cyc(3);
        rst = 1'b1; run = 1'b1; ack = 1'b1;
        cyc(1);
        check("r_busy", 32'(ifa.frame_busy), 32'd0);
        check("r_cnt", ifa.frame_cnt, 32'd0);
        rst = 1'b0; ack = 1'b0;
        cyc(11);
        check("r_tick", 32'(ifa.frame_tick), 32'd1);
        check("r_cnt1", ifa.frame_cnt, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
